dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder side of the data-path MEM-stage load/store interface: accepts one request
//  at a time over a valid/ready handshake, performs it on a word-organised on-chip
//  array and returns a single-cycle response after a programmable latency.
//  Models the timing of the future DDR3-backed data port; o_busy feeds the hazard unit.
// PARAMETERS
//  DATA_WIDTH   32  word width; byte enables are DATA_WIDTH/8 bits wide
//  ADDR_WIDTH   32  byte-address width of i_req_addr
//  MEM_DEPTH    32  number of words in the array (power of two)
//  RSP_LATENCY  2   cycles from accept edge to o_rsp_valid; legal range 1..15
// PORTS
//  i_clk        in   1               clock
//  i_reset_n    in   1               synchronous active-low reset
//  i_req_valid  in   1               request present
//  o_req_ready  out  1               responder can accept (high only in IDLE)
//  i_req_we     in   1               1 = store, 0 = load
//  i_req_addr   in   ADDR_WIDTH      byte address; word index = addr[2 +: log2(MEM_DEPTH)]
//  i_req_wdata  in   DATA_WIDTH      store data, lane-aligned by the requester
//  i_req_be     in   DATA_WIDTH/8    byte-lane enables (stores only; ignored on loads)
//  o_rsp_valid  out  1               one-cycle response strobe (loads and stores)
//  o_rsp_rdata  out  DATA_WIDTH      load data; 0 for stores and errored requests
//  o_rsp_err    out  1               request address out of range; valid with o_rsp_valid
//  o_busy       out  1               request in flight (state != IDLE)
// BEHAVIOUR
//  - Reset: state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_busy=0.
//    Array contents are not cleared by reset; array is zero at time 0.
//  - Accept: edge T where i_req_valid & o_req_ready. Request fields are captured at T;
//    inputs after T are don't-care until next accept.
//  - Store: array lanes with be[i]=1 written at edge T; be=0 is a legal no-op.
//  - Load: word read at edge T into a hold register (sees stores committed before T).
//  - Range: addr >> 2 >= MEM_DEPTH, or any bit above the index field set -> error:
//    no write, rdata=0, o_rsp_err=1. addr[1:0] ignored (lanes selected via be).
//  - FSM: IDLE -accept-> WAIT (RSP_LATENCY>1) or RESP (RSP_LATENCY==1).
//    WAIT: down-counter loaded with RSP_LATENCY-2 at T; when it is 0 -> RESP.
//    RESP: o_rsp_valid=1, rdata/err driven for exactly this cycle -> IDLE.
//  - Timing: o_rsp_valid high in cycle T+RSP_LATENCY; o_req_ready returns in cycle
//    T+RSP_LATENCY+1. Max throughput 1 request per RSP_LATENCY+1 cycles.
//  - o_rsp_rdata/o_rsp_err return to 0 in every cycle o_rsp_valid=0.
//  - No response backpressure: requester must sample o_rsp_valid.
//  - i_req_valid while not ready: ignored, request held by requester (no drop).
//  - Reset mid-operation (WAIT/RESP): in-flight response aborted, no o_rsp_valid;
//    a store accepted before reset stays committed.
//  - Width rules: be width = DATA_WIDTH/8; counter 4 bits; index log2(MEM_DEPTH) bits.
// TESTING
//  - Store 0xDEADBEEF be=4'hF @0x08, then load @0x08 -> rsp_valid at T+2, rdata=0xDEADBEEF, err=0.
//  - Store 0x000000AA be=4'h1 over 0x11223344 @0x0C, load -> rdata=0x112233AA.
//  - Load @0x80 (MEM_DEPTH=32) -> rsp_valid, err=1, rdata=0; store @0x80 leaves array unchanged.
//  - Hold i_req_valid high back-to-back, RSP_LATENCY=1 and 3 -> accepts every 2 / 4 cycles,
//    o_busy high between accept and response, one rsp per request in order.
//  - Reset asserted one cycle after a store accept (LATENCY=3) -> no rsp_valid, ready=1
//    after reset, subsequent load returns stored data.
//  - Random valid/we/be/addr vs scoreboard model for 10k requests -> zero mismatches.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request and single-cycle response bus between the MEM stage
// (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_we;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic [DATA_WIDTH/8-1:0] i_req_be;
  logic                    o_rsp_valid;
  logic [DATA_WIDTH-1:0]   o_rsp_rdata;
  logic                    o_rsp_err;
  logic                    o_busy;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time on a word array, answering with a
// one-cycle response strobe RSP_LATENCY cycles after the accept edge.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 32,
  parameter int RSP_LATENCY = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam int         BE_W     = DATA_WIDTH / 8;
  localparam logic [3:0] CNT_LOAD = (RSP_LATENCY > 1) ? 4'(RSP_LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic [DATA_WIDTH-1:0]   hold_rdata_r;
  logic                    hold_err_r;
  logic                    req_ready_r;
  logic                    busy_r;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    rsp_err_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

  logic [IDX_W-1:0]        idx_s;
  logic                    addr_err_s;
  logic                    accept_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;

  // Address decode, handshake and the load word captured on the accept edge
  always_comb begin
    idx_s      = bus.i_req_addr[2 +: IDX_W];
    addr_err_s = (bus.i_req_addr >> (IDX_W + 2)) != {ADDR_WIDTH{1'b0}};
    accept_s   = i_reset_n & bus.i_req_valid & req_ready_r;
    if (addr_err_s || bus.i_req_we) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_s = mem_r[idx_s];
    end
  end

  // Byte-lane store on the accept edge; the array is deliberately left out of reset
  always_ff @(posedge i_clk) begin
    if (accept_s && bus.i_req_we && !addr_err_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.i_req_be[b]) begin
          mem_r[idx_s][8*b +: 8] <= bus.i_req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Request/response sequencer with registered handshake and response outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      hold_rdata_r <= {DATA_WIDTH{1'b0}};
      hold_err_r   <= 1'b0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= {DATA_WIDTH{1'b0}};
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {DATA_WIDTH{1'b0}};
          rsp_err_r   <= 1'b0;
          if (accept_s) begin
            req_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            hold_rdata_r <= rd_data_s;
            hold_err_r   <= addr_err_s;
            // Single-cycle latency skips WAIT and presents the response straight away
            if (RSP_LATENCY == 1) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= rd_data_s;
              rsp_err_r   <= addr_err_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= hold_rdata_r;
            rsp_err_r   <= hold_err_r;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {DATA_WIDTH{1'b0}};
          rsp_err_r   <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {DATA_WIDTH{1'b0}};
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_req_ready = req_ready_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_rsp_valid = rsp_valid_r;
  assign bus.o_rsp_rdata = rsp_rdata_r;
  assign bus.o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 1, 3) checked every cycle
// against a timestamp-based model, plus directed literal checks.
module tb_dmem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 32;
  localparam int NI    = 3;
  localparam int LIMIT = 64;

  function automatic int lat_of(input int i);
    if (i == 0) return 2;
    else if (i == 1) return 1;
    else return 3;
  endfunction

  logic          clk;
  logic          rst_n;
  logic          req_valid [NI];
  logic          req_we    [NI];
  logic [AW-1:0] req_addr  [NI];
  logic [DW-1:0] req_wdata [NI];
  logic [3:0]    req_be    [NI];
  logic          req_ready [NI];
  logic          rsp_valid [NI];
  logic [DW-1:0] rsp_rdata [NI];
  logic          rsp_err   [NI];
  logic          busy      [NI];

  dmem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bus[g].i_req_valid = req_valid[g];
    assign bus[g].i_req_we    = req_we[g];
    assign bus[g].i_req_addr  = req_addr[g];
    assign bus[g].i_req_wdata = req_wdata[g];
    assign bus[g].i_req_be    = req_be[g];
    assign req_ready[g] = bus[g].o_req_ready;
    assign rsp_valid[g] = bus[g].o_rsp_valid;
    assign rsp_rdata[g] = bus[g].o_rsp_rdata;
    assign rsp_err[g]   = bus[g].o_rsp_err;
    assign busy[g]      = bus[g].o_busy;

    dmem_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RSP_LATENCY(lat_of(g))
    ) u_dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .bus      (bus[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Model: cycle k is the period after clock edge k. An accept on edge k (handshake
  // seen in cycle k-1) answers in cycle k+L-1 and frees the port from cycle k+L.
  longint        cyc = 0;
  longint        rdy_cyc  [NI];
  longint        rsp_cyc  [NI];
  logic [DW-1:0] exp_data [NI];
  logic          exp_err  [NI];
  int            mdl_acc  [NI];
  logic [DW-1:0] mdl_mem  [NI][DEPTH];

  initial begin
    for (int i = 0; i < NI; i++) begin
      rdy_cyc[i] = 0; rsp_cyc[i] = -1; exp_data[i] = '0; exp_err[i] = 1'b0; mdl_acc[i] = 0;
      for (int w = 0; w < DEPTH; w++) mdl_mem[i][w] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        logic [63:0] word;
        int          idx;
        logic        err;
        if (!rst_n) begin
          rdy_cyc[i] = cyc;
          rsp_cyc[i] = -1;
        end else if (req_valid[i] && (cyc - 1 >= rdy_cyc[i])) begin
          word = {32'd0, req_addr[i]} >> 2;
          err  = word >= 64'(DEPTH);
          idx  = int'(word % 64'(DEPTH));
          exp_err[i]  = err;
          exp_data[i] = '0;
          if (!err && req_we[i]) begin
            for (int b = 0; b < 4; b++)
              if (req_be[i][b]) mdl_mem[i][idx][8*b +: 8] = req_wdata[i][8*b +: 8];
          end else if (!err) begin
            exp_data[i] = mdl_mem[i][idx];
          end
          rsp_cyc[i] = cyc + lat_of(i) - 1;
          rdy_cyc[i] = cyc + lat_of(i);
          mdl_acc[i]++;
        end
      end
    end
  end

  // Per-cycle comparison and bookkeeping of what the DUTs actually did
  int            dut_rsp_n [NI];
  int            dut_hs_n  [NI];
  longint        dut_rsp_at[NI];
  longint        dut_hs_at [NI];
  longint        dut_hs_gap[NI];
  logic [DW-1:0] dut_last_rdata [NI];
  logic          dut_last_err   [NI];
  logic          prev_rdy [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      dut_rsp_n[i] = 0; dut_hs_n[i] = 0; dut_rsp_at[i] = 0; dut_hs_at[i] = 0;
      dut_hs_gap[i] = 0; dut_last_rdata[i] = '0; dut_last_err[i] = 1'b0; prev_rdy[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        logic       e_rdy;
        logic       e_v;
        logic [35:0] e;
        logic [35:0] a;
        e_rdy = cyc >= rdy_cyc[i];
        e_v   = cyc == rsp_cyc[i];
        e = {e_rdy, e_v, ~e_rdy, (e_v ? exp_err[i] : 1'b0), (e_v ? exp_data[i] : 32'd0)};
        a = {req_ready[i], rsp_valid[i], busy[i], rsp_err[i], rsp_rdata[i]};
        chk($sformatf("outputs[%0d]@%0d {rdy,vld,busy,err,rdata}", i, cyc), 64'(a), 64'(e));
        if (rsp_valid[i]) begin
          dut_rsp_n[i]++;
          dut_rsp_at[i]     = cyc;
          dut_last_rdata[i] = rsp_rdata[i];
          dut_last_err[i]   = rsp_err[i];
        end
        // Inputs seen here were sampled by the edge just taken, against last cycle's ready
        if (req_valid[i] && rst_n && prev_rdy[i]) begin
          dut_hs_gap[i] = (cyc - 1) - dut_hs_at[i];
          dut_hs_at[i]  = cyc - 1;
          dut_hs_n[i]++;
        end
        prev_rdy[i] = req_ready[i];
      end
    end
  end

  task automatic do_req(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be);
    int   t;
    logic ok;
    req_we[i] = we; req_addr[i] = a; req_wdata[i] = d; req_be[i] = be; req_valid[i] = 1'b1;
    t = 0;
    while (!req_ready[i] && t < LIMIT) begin @(negedge clk); t++; end
    ok = req_ready[i];
    @(negedge clk);
    req_valid[i] = 1'b0;
    chk($sformatf("accept_wait[%0d]", i), 64'(ok), 64'd1);
    t = 0;
    while (!req_ready[i] && t < LIMIT) begin @(negedge clk); t++; end
    chk($sformatf("ready_return[%0d]", i), 64'(req_ready[i]), 64'd1);
  endtask

  initial begin
    int rsp0;
    int hs1;
    int hs2;
    int r1;
    int r2;
    int sel;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_ready", 64'(req_ready[i]), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid[i]), 64'd0);
      chk("reset_rdata", 64'(rsp_rdata[i]), 64'd0);
      chk("reset_err", 64'(rsp_err[i]), 64'd0);
      chk("reset_busy", 64'(busy[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NI; i++)
      for (int w = 0; w < DEPTH; w++) do_req(i, 1'b1, AW'(w * 4), $urandom, 4'hF);

    // Full-word store then load
    do_req(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
    do_req(0, 1'b0, 32'h08, 32'h0, 4'h0);
    chk("ld08_rdata", 64'(dut_last_rdata[0]), 64'hDEADBEEF);
    chk("ld08_err", 64'(dut_last_err[0]), 64'd0);
    chk("ld08_latency", 64'(dut_rsp_at[0] - dut_hs_at[0]), 64'd2);
    chk("model_ld08", 64'(exp_data[0]), 64'hDEADBEEF);
    do_req(0, 1'b0, 32'h0B, 32'h0, 4'h0);
    chk("ld0b_low_bits_ignored", 64'(dut_last_rdata[0]), 64'hDEADBEEF);

    // Partial lane store and an all-lanes-off store
    do_req(0, 1'b1, 32'h0C, 32'h11223344, 4'hF);
    do_req(0, 1'b1, 32'h0C, 32'h000000AA, 4'h1);
    do_req(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0);
    do_req(0, 1'b0, 32'h0C, 32'h0, 4'h0);
    chk("ld0c_lane0", 64'(dut_last_rdata[0]), 64'h112233AA);
    chk("model_ld0c", 64'(exp_data[0]), 64'h112233AA);

    // Out-of-range accesses
    do_req(0, 1'b1, 32'h00, 32'h01234567, 4'hF);
    do_req(0, 1'b0, 32'h80, 32'h0, 4'h0);
    chk("ld80_err", 64'(dut_last_err[0]), 64'd1);
    chk("ld80_rdata", 64'(dut_last_rdata[0]), 64'd0);
    do_req(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF);
    chk("st80_err", 64'(dut_last_err[0]), 64'd1);
    do_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    chk("ld_high_bit_err", 64'(dut_last_err[0]), 64'd1);
    do_req(0, 1'b0, 32'h00, 32'h0, 4'h0);
    chk("ld00_untouched", 64'(dut_last_rdata[0]), 64'h01234567);
    chk("model_ld00", 64'(exp_data[0]), 64'h01234567);

    // Back-to-back held requests on latency 1 and 3
    hs1 = dut_hs_n[1]; hs2 = dut_hs_n[2]; r1 = dut_rsp_n[1]; r2 = dut_rsp_n[2];
    for (int i = 1; i < NI; i++) begin
      req_we[i] = 1'b0; req_addr[i] = 32'h08; req_be[i] = 4'h0; req_valid[i] = 1'b1;
    end
    repeat (20) @(negedge clk);
    req_valid[1] = 1'b0; req_valid[2] = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_gap_lat1", 64'(dut_hs_gap[1]), 64'd2);
    chk("b2b_gap_lat3", 64'(dut_hs_gap[2]), 64'd4);
    chk("b2b_accepts_lat1", 64'(dut_hs_n[1] - hs1), 64'd10);
    chk("b2b_accepts_lat3", 64'(dut_hs_n[2] - hs2), 64'd5);
    chk("b2b_rsps_lat1", 64'(dut_rsp_n[1] - r1), 64'd10);
    chk("b2b_rsps_lat3", 64'(dut_rsp_n[2] - r2), 64'd5);

    // Reset one cycle after a store accept on latency 3
    rsp0 = dut_rsp_n[2];
    req_we[2] = 1'b1; req_addr[2] = 32'h10; req_wdata[2] = 32'hCAFEF00D; req_be[2] = 4'hF;
    req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_abort_no_rsp", 64'(dut_rsp_n[2] - rsp0), 64'd0);
    chk("rst_ready", 64'(req_ready[2]), 64'd1);
    do_req(2, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rst_store_kept", 64'(dut_last_rdata[2]), 64'hCAFEF00D);

    // Randomized traffic, fields re-drawn every cycle, rare resets
    repeat (12000) begin
      for (int i = 0; i < NI; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        req_we[i]    = 1'($urandom_range(0, 1));
        req_be[i]    = 4'($urandom);
        req_wdata[i] = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) req_addr[i] = $urandom;
        else if (sel == 1) req_addr[i] = 32'h80 + AW'($urandom_range(0, 127));
        else req_addr[i] = AW'($urandom_range(0, 127));
      end
      rst_n = ($urandom_range(0, 2999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) req_valid[i] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("accept_count[%0d]", i), 64'(dut_hs_n[i]), 64'(mdl_acc[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
